cdm_mul_arbiter: RTL and testbench
==================================

Name: cdm_mul_arbiter

Overview:
- Shares one 16x16 carry-disregard approximate multiplier (e.g. cdm16_f883) between N_REQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Drives the multiplier's operand inputs from registers and waits a configurable number of cycles.
- Captures the 32-bit product and returns it with the requester ID on a single valid/ready response port.
- Sits between traffic sources (accelerator lanes, error-analysis harness) and the multiplier instance.

Parameters:
- N_REQ, 4, number of requesters; 2..2^ID_W.
- ID_W, 2, width of the requester ID on resp_id.
- MUL_LAT, 1, cycles the operands are held before the product is sampled; must be >= 1.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  16*N_REQ  packed operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*N_REQ  packed operand B; same packing.
- req_ready  out  N_REQ  one-hot grant/accept pulse.
- mul_a  out  16  registered operand A to the multiplier.
- mul_b  out  16  registered operand B to the multiplier.
- mul_r  in  32  multiplier product (combinational from mul_a/mul_b).
- resp_valid  out  1  product valid.
- resp_ready  in  1  response consumer ready.
- resp_data  out  32  captured product.
- resp_id  out  ID_W  index of the requester that issued the operation.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; rr_ptr=N_REQ-1, so requester 0 has first priority.
  - req_ready=0, mul_a=0, mul_b=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, wait counter=0.
  - Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Scan req_valid from (rr_ptr+1) mod N_REQ upward with wrap; the first set bit wins (index g).
  - If any request is valid: req_ready[g]=1 combinationally in this cycle only; this cycle is the handshake.
  - At the edge: mul_a<=req_a[g], mul_b<=req_b[g], id<=g, rr_ptr<=g, cnt<=MUL_LAT-1, state<=WAIT.
  - If no request is valid: stay in IDLE; all req_ready=0.
- WAIT:
  - mul_a/mul_b held stable; req_ready=0.
  - If cnt!=0: cnt<=cnt-1.
  - Else: resp_data<=mul_r, resp_id<=id, resp_valid<=1, state<=RESP.
- RESP:
  - resp_valid, resp_data and resp_id held stable until resp_ready=1.
  - On handshake: resp_valid<=0, state<=IDLE. The next grant occurs in the following IDLE cycle at the earliest.
- Latency: handshake cycle t gives resp_valid high at cycle t+MUL_LAT+1. Minimum issue spacing is MUL_LAT+2 cycles with resp_ready tied high.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,2,3,0,...
  - A requester just granted has lowest priority next round.
- Request-side rules:
  - A requester may drop req_valid without a grant; this has no effect.
  - req_a/req_b are sampled only in the grant cycle.
  - req_valid bits at index >= N_REQ do not exist; ID values >= N_REQ never occur.
- Arithmetic: no modification of the product. resp_data equals mul_r as sampled, including approximation error; the block never computes A*B itself.
- busy=1 in WAIT and RESP.

Optional Feature:
- Macro: CDM_ARB_STATS_EN.
- Defined: adds output op_count (32 bits).
  - Reset to 0; increments by 1 on each resp_valid&resp_ready handshake.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Multiplier stub mul_r=mul_a*mul_b, MUL_LAT=1: only req 2 valid with a=3, b=5.
  - Required: req_ready=4'b0100 for one cycle.
  - resp_valid 2 cycles after the grant, with resp_data=15 and resp_id=2.
- All 4 requesters valid continuously with a=i+1, b=10, resp_ready=1.
  - Required grant order 0,1,2,3,0.
  - resp_data sequence 10,20,30,40,10; issue spacing 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid.
  - Required: resp_data/resp_id stable, busy=1, no req_ready pulses.
  - After resp_ready=1 for one cycle: resp_valid=0 next cycle.
- MUL_LAT=3, a=0xFFFF, b=0xFFFF.
  - Required: mul_a/mul_b stable for 3 cycles after the grant.
  - resp_valid at grant+4; resp_data equals the stub output 0xFFFE0001.
- Assert rst_n=0 during WAIT.
  - Required: next cycle all outputs 0, state IDLE, no resp_valid.
  - The first grant after reset goes to req 0 when reqs 0 and 3 are both valid.
- With CDM_ARB_STATS_EN: 6 completed transactions give op_count=6. A dropped request does not increment it, and op_count returns to 0 on reset.

Source files
------------

// File: rtl/cdm_mul_arbiter.sv
// cdm_mul_arbiter: round-robin front end sharing one 16x16 approximate multiplier
// between N_REQ valid/ready requesters; returns product plus requester ID.
// Optional macro CDM_ARB_STATS_EN adds a 32-bit completed-operation counter (op_count).
module cdm_mul_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [31:0]           mul_r,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
`ifdef CDM_ARB_STATS_EN
  ,
  output logic [31:0]           op_count
`endif
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   scan_idx;
  logic [15:0]       sel_a;
  logic [15:0]       sel_b;

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and grant pulse; grant is suppressed while reset is asserted
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (rst_n && gnt_found) begin
          req_ready = N_REQ'(1) << gnt_idx;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand launch, latency count and product capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= ID_W'(N_REQ - 1);
      id         <= '0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            id     <= gnt_idx;
            rr_ptr <= gnt_idx;
            cnt    <= CNT_W'(MUL_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_data  <= mul_r;
            resp_id    <= id;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CDM_ARB_STATS_EN
  // Completed response handshakes, free-running with wrap
  always_ff @(posedge clk) begin
    if (!rst_n)                         op_count <= '0;
    else if (resp_valid && resp_ready)  op_count <= op_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cdm_mul_arbiter.sv
// Directed bench for cdm_mul_arbiter: one instance with MUL_LAT=1, one with MUL_LAT=3,
// each fed by an exact-multiply stub. Stats checks are built when CDM_ARB_STATS_EN is defined.
module tb_cdm_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  d1_req_valid, d3_req_valid;
  logic [63:0] d1_req_a, d1_req_b, d3_req_a, d3_req_b;
  logic [3:0]  d1_req_ready, d3_req_ready;
  logic [15:0] d1_mul_a, d1_mul_b, d3_mul_a, d3_mul_b;
  logic [31:0] d1_mul_r, d3_mul_r;
  logic        d1_resp_valid, d3_resp_valid;
  logic        d1_resp_ready, d3_resp_ready;
  logic [31:0] d1_resp_data, d3_resp_data;
  logic [1:0]  d1_resp_id, d3_resp_id;
  logic        d1_busy, d3_busy;
`ifdef CDM_ARB_STATS_EN
  logic [31:0] d1_op_count, d3_op_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign d1_mul_r = {16'd0, d1_mul_a} * {16'd0, d1_mul_b};
  assign d3_mul_r = {16'd0, d3_mul_a} * {16'd0, d3_mul_b};

  cdm_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d1_req_valid), .req_a(d1_req_a), .req_b(d1_req_b), .req_ready(d1_req_ready),
    .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_r(d1_mul_r),
    .resp_valid(d1_resp_valid), .resp_ready(d1_resp_ready),
    .resp_data(d1_resp_data), .resp_id(d1_resp_id), .busy(d1_busy)
`ifdef CDM_ARB_STATS_EN
    , .op_count(d1_op_count)
`endif
  );

  cdm_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d3_req_valid), .req_a(d3_req_a), .req_b(d3_req_b), .req_ready(d3_req_ready),
    .mul_a(d3_mul_a), .mul_b(d3_mul_b), .mul_r(d3_mul_r),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready),
    .resp_data(d3_resp_data), .resp_id(d3_resp_id), .busy(d3_busy)
`ifdef CDM_ARB_STATS_EN
    , .op_count(d3_op_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic zero_inputs;
    d1_req_valid = '0; d1_req_a = '0; d1_req_b = '0; d1_resp_ready = 1'b0;
    d3_req_valid = '0; d3_req_a = '0; d3_req_b = '0; d3_resp_ready = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    zero_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    zero_inputs();
    d1_req_valid = 4'b1111;
    tick();
    tick();
    #1;
    checks++; if (d1_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", d1_req_ready); end
    checks++; if (d1_mul_a !== 16'd0 || d1_mul_b !== 16'd0) begin errors++; $display("FAIL reset_mul_ab: got %h/%h expected 0/0", d1_mul_a, d1_mul_b); end
    checks++; if (d1_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", d1_resp_valid); end
    checks++; if (d1_resp_data !== 32'd0 || d1_resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_data_id: got %h/%0d expected 0/0", d1_resp_data, d1_resp_id); end
    checks++; if (d1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", d1_busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (d1_req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_priority: got %b expected 0001", d1_req_ready); end
    d1_req_valid = '0;
  endtask

  task automatic test_single;
    apply_reset();
    d1_req_valid = 4'b0100;
    d1_req_a[47:32] = 16'd3;
    d1_req_b[47:32] = 16'd5;
    #1;
    checks++; if (d1_req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", d1_req_ready); end
    tick();
    checks++; if (d1_req_ready !== 4'b0000) begin errors++; $display("FAIL single_grant_pulse: got %b expected 0000", d1_req_ready); end
    checks++; if (d1_resp_valid !== 1'b0 || d1_busy !== 1'b1) begin errors++; $display("FAIL single_wait: got valid=%b busy=%b expected 0/1", d1_resp_valid, d1_busy); end
    checks++; if (d1_mul_a !== 16'd3 || d1_mul_b !== 16'd5) begin errors++; $display("FAIL single_operands: got %0d/%0d expected 3/5", d1_mul_a, d1_mul_b); end
    tick();
    checks++; if (d1_resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", d1_resp_valid); end
    checks++; if (d1_resp_data !== 32'd15 || d1_resp_id !== 2'd2) begin errors++; $display("FAIL single_resp: got %0d id %0d expected 15 id 2", d1_resp_data, d1_resp_id); end
    d1_resp_ready = 1'b1;
    d1_req_valid = '0;
    tick();
    checks++; if (d1_resp_valid !== 1'b0 || d1_busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid=%b busy=%b expected 0/0", d1_resp_valid, d1_busy); end
    d1_resp_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int ng = 0;
    int nr = 0;
    int last = 0;
    apply_reset();
    d1_req_a = {16'd4, 16'd3, 16'd2, 16'd1};
    d1_req_b = {16'd10, 16'd10, 16'd10, 16'd10};
    d1_resp_ready = 1'b1;
    d1_req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (d1_req_ready !== 4'b0000 && ng < 5) begin
        checks++; if (d1_req_ready !== (4'b0001 << exp_g[ng])) begin errors++; $display("FAIL rr_grant%0d: got %b expected req %0d", ng, d1_req_ready, exp_g[ng]); end
        if (ng > 0) begin
          checks++; if (cyc - last != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", ng, cyc - last); end
        end
        last = cyc;
        ng++;
      end
      if (d1_resp_valid === 1'b1 && nr < 5) begin
        checks++;
        if (d1_resp_data !== 32'(10 * (exp_g[nr] + 1)) || d1_resp_id !== 2'(exp_g[nr])) begin
          errors++; $display("FAIL rr_resp%0d: got %0d id %0d expected %0d id %0d", nr, d1_resp_data, d1_resp_id, 10 * (exp_g[nr] + 1), exp_g[nr]);
        end
        nr++;
      end
      tick();
      #1;
    end
    checks++; if (ng != 5 || nr != 5) begin errors++; $display("FAIL rr_count: got grants=%0d resps=%0d expected 5/5", ng, nr); end
    d1_req_valid = '0;
    d1_resp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int n = 0;
    apply_reset();
    d1_req_valid = 4'b0001;
    d1_req_a[15:0] = 16'd7;
    d1_req_b[15:0] = 16'd6;
    #1;
    checks++; if (d1_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b expected 0001", d1_req_ready); end
    tick();
    d1_req_valid = 4'b1111;
    while (d1_resp_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (d1_resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout: got %b expected 1", d1_resp_valid); end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (d1_resp_valid !== 1'b1 || d1_resp_data !== 32'd42 || d1_resp_id !== 2'd0) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d id=%0d expected 1/42/0", k, d1_resp_valid, d1_resp_data, d1_resp_id); end
      checks++; if (d1_busy !== 1'b1) begin errors++; $display("FAIL bp_busy%0d: got %b expected 1", k, d1_busy); end
      checks++; if (d1_req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant%0d: got %b expected 0000", k, d1_req_ready); end
      tick();
    end
    d1_resp_ready = 1'b1;
    d1_req_valid = '0;
    tick();
    checks++; if (d1_resp_valid !== 1'b0 || d1_busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b expected 0/0", d1_resp_valid, d1_busy); end
    d1_resp_ready = 1'b0;
  endtask

  task automatic test_latency3;
    apply_reset();
    d3_req_valid = 4'b0010;
    d3_req_a[31:16] = 16'hFFFF;
    d3_req_b[31:16] = 16'hFFFF;
    #1;
    checks++; if (d3_req_ready !== 4'b0010) begin errors++; $display("FAIL lat3_grant: got %b expected 0010", d3_req_ready); end
    tick();
    d3_req_valid = '0;
    d3_req_a = '0;
    d3_req_b = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (d3_mul_a !== 16'hFFFF || d3_mul_b !== 16'hFFFF) begin errors++; $display("FAIL lat3_hold%0d: got %h/%h expected ffff/ffff", k, d3_mul_a, d3_mul_b); end
      checks++; if (d3_resp_valid !== 1'b0) begin errors++; $display("FAIL lat3_early%0d: got %b expected 0", k, d3_resp_valid); end
      tick();
    end
    checks++; if (d3_resp_valid !== 1'b1) begin errors++; $display("FAIL lat3_resp_valid: got %b expected 1", d3_resp_valid); end
    checks++; if (d3_resp_data !== 32'hFFFE0001 || d3_resp_id !== 2'd1) begin errors++; $display("FAIL lat3_resp: got %h id %0d expected fffe0001 id 1", d3_resp_data, d3_resp_id); end
    d3_resp_ready = 1'b1;
    tick();
    d3_resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    apply_reset();
    d3_req_valid = 4'b0100;
    d3_req_a[47:32] = 16'd5;
    d3_req_b[47:32] = 16'd5;
    tick();
    d3_req_valid = '0;
    tick();
    checks++; if (d3_busy !== 1'b1 || d3_resp_valid !== 1'b0) begin errors++; $display("FAIL rstw_in_wait: got busy=%b v=%b expected 1/0", d3_busy, d3_resp_valid); end
    rst_n = 1'b0;
    tick();
    #1;
    checks++; if (d3_mul_a !== 16'd0 || d3_mul_b !== 16'd0 || d3_req_ready !== 4'b0000) begin errors++; $display("FAIL rstw_outputs: got a=%h b=%h rdy=%b expected 0", d3_mul_a, d3_mul_b, d3_req_ready); end
    checks++; if (d3_resp_valid !== 1'b0 || d3_resp_data !== 32'd0 || d3_resp_id !== 2'd0 || d3_busy !== 1'b0) begin errors++; $display("FAIL rstw_resp: got v=%b d=%h id=%0d busy=%b expected 0", d3_resp_valid, d3_resp_data, d3_resp_id, d3_busy); end
    tick();
    checks++; if (d3_resp_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_resp: got %b expected 0", d3_resp_valid); end
    d3_req_a = {16'd33, 32'd0, 16'd11};
    d3_req_b = {16'd2, 32'd0, 16'd2};
    d3_req_valid = 4'b1001;
    rst_n = 1'b1;
    #1;
    checks++; if (d3_req_ready !== 4'b0001) begin errors++; $display("FAIL rstw_first_grant: got %b expected 0001", d3_req_ready); end
    tick();
    d3_req_valid = '0;
    checks++; if (d3_mul_a !== 16'd11) begin errors++; $display("FAIL rstw_operand: got %0d expected 11", d3_mul_a); end
  endtask

`ifdef CDM_ARB_STATS_EN
  task automatic test_stats;
    int grants = 0;
    int n = 0;
    int phase = 0;
    apply_reset();
    checks++; if (d1_op_count !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", d1_op_count); end
    d1_req_a[15:0] = 16'd2;
    d1_req_b[15:0] = 16'd3;
    d1_resp_ready = 1'b1;
    d1_req_valid = 4'b0001;
    #1;
    while (grants < 6 && n < 60) begin
      checks++; if (d1_req_ready[1] !== 1'b0) begin errors++; $display("FAIL stats_dropped_grant: got %b expected bit1=0", d1_req_ready); end
      if (d1_req_ready[0] === 1'b1) grants++;
      tick();
      n++;
      if (phase == 1) begin d1_req_valid = 4'b0001; phase = 2; end
      if (grants == 3 && phase == 0) begin d1_req_valid = 4'b0011; phase = 1; end
      #1;
    end
    d1_req_valid = '0;
    while (d1_busy !== 1'b0 && n < 60) begin tick(); n++; end
    checks++; if (grants != 6 || d1_busy !== 1'b0) begin errors++; $display("FAIL stats_run: got grants=%0d busy=%b expected 6/0", grants, d1_busy); end
    checks++; if (d1_op_count !== 32'd6) begin errors++; $display("FAIL stats_count: got %0d expected 6", d1_op_count); end
    d1_resp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (d1_op_count !== 32'd0) begin errors++; $display("FAIL stats_clear: got %0d expected 0", d1_op_count); end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    zero_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency3();
    test_reset_mid_wait();
`ifdef CDM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
